// File: rtl/e_walk_if.sv
// e_walk_if: stream bundle for the free-slot enumerator.
//   Bitmap load side: in_vld_i / in_rdy_o / in_x_i.
//   Index stream side: out_vld_o / out_rdy_i / out_idx_o / out_eos_o.
//   busy_o: a walk is in progress.
// The slave modport is the enumerator. The master modport is the producer/consumer pair.
interface e_walk_if #(
  parameter int W    = 4,
  parameter int SEGS = 4
);
  localparam int IDXW = $clog2(W*SEGS);

  logic              in_vld_i;
  logic              in_rdy_o;
  logic [W*SEGS-1:0] in_x_i;
  logic              out_vld_o;
  logic              out_rdy_i;
  logic [IDXW-1:0]   out_idx_o;
  logic              out_eos_o;
  logic              busy_o;

  modport master (
    output in_vld_i, in_x_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_idx_o, out_eos_o, busy_o
  );

  modport slave (
    input  in_vld_i, in_x_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_idx_o, out_eos_o, busy_o
  );
endinterface

// File: rtl/e_walk.sv
// e_walk: sequential free-slot enumerator.
//   A W*SEGS-bit occupancy bitmap (1 = occupied) is loaded, then walked MSB-first, one
//   W-bit segment per scan cycle. Every free bit position is emitted as one beat on the
//   output stream. One end-of-scan beat (idx 0) follows the last position.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - e_walk_if.slave (load stream, index stream, busy)
// Steady throughput is one index per two cycles (SCAN then EMIT). Each empty segment costs one cycle.

// e_cell: per-segment first-free finder.
//   With carry=1 it finds the first zero of x, MSB-first.
//   With carry=0 it finds the first zero strictly below the one-hot sel.
//   It returns the new one-hot sel and the bit position of that zero.
module e_cell #(
  parameter int W = 4
) (
  input  logic [W-1:0]         x_i,
  input  logic [W-1:0]         sel_i,
  input  logic                 carry_i,
  output logic                 hit_o,
  output logic [W-1:0]         sel_o,
  output logic [$clog2(W)-1:0] pos_o
);
  logic [W-1:0] mask;
  logic [W-1:0] free;

  // sel - 1 sets every bit strictly below the one-hot position.
  assign mask = carry_i ? '1 : (sel_i - W'(1));
  assign free = ~x_i & mask;

  always_comb begin
    hit_o = 1'b0;
    pos_o = '0;
    sel_o = '0;
    // Ascending scan: the last match is the highest free bit.
    for (int b = 0; b < W; b++) begin
      if (free[b]) begin
        hit_o = 1'b1;
        pos_o = ($clog2(W))'(b);
      end
    end
    if (hit_o) sel_o[pos_o] = 1'b1;
  end
endmodule

module e_walk #(
  parameter int W    = 4,
  parameter int SEGS = 4
) (
  input logic   clk,
  input logic   rst,
  e_walk_if.slave bus
);
  localparam int N    = W*SEGS;
  localparam int IDXW = $clog2(N);
  localparam int SEGW = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int PW   = $clog2(W);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, EOS} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    bm_q, bm_d;
  logic [SEGW-1:0] seg_q, seg_d;
  logic [W-1:0]    sel_q, sel_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [W-1:0]    seg_x;
  logic            cell_hit;
  logic [W-1:0]    cell_sel;
  logic [PW-1:0]   cell_pos;
  logic [IDXW-1:0] idx_hit;
  logic            last_seg;

  // Segment s occupies bits [N-1-s*W -: W]. Shifting it down to the LSBs selects it.
  assign seg_x    = W'(bm_q >> (W*(SEGS-1-int'(seg_q))));
  assign last_seg = (int'(seg_q) == SEGS-1);

  e_cell #(.W(W)) u_cell (
    .x_i    (seg_x),
    .sel_i  (sel_q),
    .carry_i(carry_q),
    .hit_o  (cell_hit),
    .sel_o  (cell_sel),
    .pos_o  (cell_pos)
  );

  // Offset within the segment counts MSB-first, so offset = W-1-pos.
  assign idx_hit = IDXW'((N-1) - (int'(seg_q)*W + (W-1-int'(cell_pos))));

  always_comb begin
    state_d = state_q;
    bm_d    = bm_q;
    seg_d   = seg_q;
    sel_d   = sel_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_vld_i) begin
          bm_d    = bus.in_x_i;
          seg_d   = '0;
          carry_d = 1'b1;
          sel_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cell_hit) begin
          idx_d   = idx_hit;
          sel_d   = cell_sel;
          state_d = EMIT;
        end else if (last_seg) begin
          state_d = EOS;
        end else begin
          seg_d   = seg_q + SEGW'(1);
          carry_d = 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_rdy_i) begin
          carry_d = 1'b0;
          state_d = SCAN;
        end
      end
      EOS: begin
        if (bus.out_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bm_q    <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bm_q    <= bm_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  // While reset is held, no load is accepted.
  assign bus.in_rdy_o  = (state_q == IDLE) & ~rst;
  assign bus.out_vld_o = (state_q == EMIT) | (state_q == EOS);
  assign bus.out_eos_o = (state_q == EOS);
  assign bus.out_idx_o = (state_q == EMIT) ? idx_q : '0;
  assign bus.busy_o    = (state_q != IDLE);
endmodule
